aes_decrypt_controller: RTL

- Sequencing FSM for the AES-128 inverse cipher; the decryption counterpart of the encryption controller on the same AHB-slave-style host interface.
- Loads the cipher key, then expands and stores all eleven round keys.
- Per ciphertext block, drives the inverse datapath units in the inverse-cipher order: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
- Round keys are consumed in reverse order (10 down to 0).

---
 rtl/aes_dec_pkg.sv | 34 +++
 rtl/aes_decrypt_controller_if.sv | 52 +++++
 rtl/aes_round_counter.sv | 35 +++
 rtl/aes_decrypt_controller.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_dec_pkg.sv
// Shared definitions for the AES-128 inverse-cipher controller.
//   - state_t      : controller FSM state encoding
//   - DEF_*        : default values for round count, counter width, step limit
// Optional build macro: AES_DEC_TIMEOUT_EN adds the ERR state.
package aes_dec_pkg;

    localparam int DEF_NUM_ROUNDS = 10;
    localparam int DEF_ROUND_W    = 4;
    localparam int DEF_TIMEOUT    = 255;

    typedef enum logic [4:0] {
        KIDLE,
        KADDR,
        KWAIT,
        KLOAD,
        KEXP,
        IDLE,
        ADDR,
        WAIT,
        LOAD,
        ARK0,
        ISROWS,
        ISBYTES,
        ARK,
        IMCOL,
        DONE,
        SEND
`ifdef AES_DEC_TIMEOUT_EN
        ,
        ERR
`endif
    } state_t;

endpackage

// File: rtl/aes_decrypt_controller_if.sv
// Host bus and inverse-datapath handshake bundle for aes_decrypt_controller.
//   slave  modport : controller side (consumes requests/finished, drives enables)
//   master modport : host + datapath side
//
// Handshake: each *_enable stays high for as long as the controller sits in the
// matching state; the unit answers with its *_finished, and the controller
// leaves the state on the clock edge where *_finished is sampled high. A
// finished strobe seen while its enable is low has no effect. HREADYOUT,
// readk_enable, read_enable and write_enable are single-cycle strobes.
interface aes_decrypt_controller_if #(
    parameter int ROUND_W = 4
);
    logic               HSELx;
    logic               addrMatch;
    logic               mWrite;
    logic               mRead;
    logic               key_sel;
    logic               dataReady;
    logic               keyexp_finished;
    logic               isbytes_finished;
    logic               isrows_finished;
    logic               imcol_finished;
    logic               around_finished;
    logic               HREADYOUT;
    logic               readk_enable;
    logic               read_enable;
    logic               write_enable;
    logic               keyexp_enable;
    logic               isbytes_enable;
    logic               isrows_enable;
    logic               imcol_enable;
    logic               around_enable;
    logic [ROUND_W-1:0] round_key_idx;

    modport slave (
        input  HSELx, addrMatch, mWrite, mRead, key_sel, dataReady,
        input  keyexp_finished, isbytes_finished, isrows_finished,
        input  imcol_finished, around_finished,
        output HREADYOUT, readk_enable, read_enable, write_enable,
        output keyexp_enable, isbytes_enable, isrows_enable,
        output imcol_enable, around_enable, round_key_idx
    );

    modport master (
        output HSELx, addrMatch, mWrite, mRead, key_sel, dataReady,
        output keyexp_finished, isbytes_finished, isrows_finished,
        output imcol_finished, around_finished,
        input  HREADYOUT, readk_enable, read_enable, write_enable,
        input  keyexp_enable, isbytes_enable, isrows_enable,
        input  imcol_enable, around_enable, round_key_idx
    );
endinterface

// File: rtl/aes_round_counter.sv
// Loadable up/down round counter.
//   clk, rst        : clock, synchronous active-high reset (count -> 0)
//   load, load_val  : parallel load (highest priority)
//   inc, dec        : step up / down; saturate at MAX / 0 so the count never wraps
//   count           : current value
//   at_zero, at_max : count == 0, count == MAX
module aes_round_counter #(
    parameter int W   = 4,
    parameter int MAX = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         at_zero,
    output logic         at_max
);
    assign at_zero = (count == '0);
    assign at_max  = (count == W'(MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && !at_max) begin
            count <= count + 1'b1;
        end else if (dec && !at_zero) begin
            count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/aes_decrypt_controller.sv
// Sequencing FSM for the AES-128 inverse cipher.
// Loads the cipher key, steps key expansion to fill round keys 1..NUM_ROUNDS,
// then per ciphertext block runs AddRoundKey(NUM_ROUNDS) followed by
// InvShiftRows / InvSubBytes / AddRoundKey / InvMixColumns rounds with the
// round keys consumed from NUM_ROUNDS-1 down to 0 (no InvMixColumns after key 0).
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : host requests, datapath enables/finished, round_key_idx
//   busy      : high from LOAD through the last AddRoundKey of a block
//   dbg_state : registered FSM state
//   err       : sticky step-timeout flag (AES_DEC_TIMEOUT_EN builds only)
// Optional build macro: AES_DEC_TIMEOUT_EN adds a per-step cycle limit
// (TIMEOUT) that traps a stalled datapath unit into the ERR state.
module aes_decrypt_controller
    import aes_dec_pkg::*;
#(
    parameter int NUM_ROUNDS = DEF_NUM_ROUNDS,
    parameter int ROUND_W    = DEF_ROUND_W
`ifdef AES_DEC_TIMEOUT_EN
    ,
    parameter int TIMEOUT    = DEF_TIMEOUT
`endif
) (
    input  logic   clk,
    input  logic   rst,
    aes_decrypt_controller_if.slave bus,
    output logic   busy,
    output state_t dbg_state
`ifdef AES_DEC_TIMEOUT_EN
    ,
    output logic   err
`endif
);

    state_t               state;
    state_t               state_next;
    logic [ROUND_W-1:0]   rnd;
    logic                 rnd_zero;
    logic                 rnd_max;
    logic                 cnt_load;
    logic [ROUND_W-1:0]   cnt_load_val;
    logic                 cnt_inc;
    logic                 cnt_dec;

    assign dbg_state = state;

    aes_round_counter #(
        .W   (ROUND_W),
        .MAX (NUM_ROUNDS)
    ) u_rnd (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .inc      (cnt_inc),
        .dec      (cnt_dec),
        .count    (rnd),
        .at_zero  (rnd_zero),
        .at_max   (rnd_max)
    );

`ifdef AES_DEC_TIMEOUT_EN
    logic [7:0] step_cnt;
    logic       err_q;
    logic       timed;
    logic       step_adv;

    assign timed    = state inside {KEXP, ARK0, ISROWS, ISBYTES, ARK, IMCOL};
    // KEXP stays in place between expansion steps, so an accepted step counts
    // as progress even without a state change.
    assign step_adv = (state_next != state) || cnt_inc;
    assign err      = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (step_adv) begin
                step_cnt <= '0;
            end else if (timed && step_cnt != 8'hFF) begin
                step_cnt <= step_cnt + 1'b1;
            end
            if (state_next == ERR) begin
                err_q <= 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= KIDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_inc      = 1'b0;
        cnt_dec      = 1'b0;
        case (state)
            KIDLE:   if (bus.HSELx) state_next = KADDR;
            KADDR:   if (bus.addrMatch && bus.mWrite) state_next = KWAIT;
            KWAIT:   if (bus.dataReady) state_next = KLOAD;
            KLOAD: begin
                state_next   = KEXP;
                cnt_load     = 1'b1;
                cnt_load_val = ROUND_W'(1);
            end
            KEXP: begin
                if (bus.keyexp_finished) begin
                    if (rnd_max) state_next = IDLE;
                    else         cnt_inc    = 1'b1;
                end
            end
            IDLE:    if (bus.HSELx) state_next = ADDR;
            ADDR: begin
                // Read has priority over a simultaneous write request.
                if (!bus.addrMatch)    state_next = IDLE;
                else if (bus.mRead)    state_next = SEND;
                else if (bus.mWrite)   state_next = bus.key_sel ? KWAIT : WAIT;
            end
            WAIT:    if (bus.dataReady) state_next = LOAD;
            LOAD:    state_next = ARK0;
            ARK0: begin
                if (bus.around_finished) begin
                    state_next   = ISROWS;
                    cnt_load     = 1'b1;
                    cnt_load_val = ROUND_W'(NUM_ROUNDS - 1);
                end
            end
            ISROWS:  if (bus.isrows_finished) state_next = ISBYTES;
            ISBYTES: if (bus.isbytes_finished) state_next = ARK;
            ARK:     if (bus.around_finished) state_next = rnd_zero ? DONE : IMCOL;
            IMCOL: begin
                if (bus.imcol_finished) begin
                    state_next = ISROWS;
                    cnt_dec    = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            SEND:    state_next = IDLE;
`ifdef AES_DEC_TIMEOUT_EN
            ERR: begin
                if (bus.HSELx && bus.addrMatch && bus.mWrite && bus.key_sel) begin
                    state_next = KWAIT;
                end
            end
`endif
            default: state_next = KIDLE;
        endcase
`ifdef AES_DEC_TIMEOUT_EN
        // No counter update happens on this path: a step that made no
        // progress never loads, increments or decrements rnd.
        if (timed && !step_adv && step_cnt == 8'(TIMEOUT - 1)) begin
            state_next = ERR;
        end
`endif
    end

    always_comb begin
        bus.HREADYOUT      = 1'b0;
        bus.readk_enable   = 1'b0;
        bus.read_enable    = 1'b0;
        bus.write_enable   = 1'b0;
        bus.keyexp_enable  = 1'b0;
        bus.isbytes_enable = 1'b0;
        bus.isrows_enable  = 1'b0;
        bus.imcol_enable   = 1'b0;
        bus.around_enable  = 1'b0;
        bus.round_key_idx  = '0;
        busy               = 1'b0;
        case (state)
            KLOAD:   bus.readk_enable = 1'b1;
            KEXP: begin
                bus.keyexp_enable = 1'b1;
                bus.round_key_idx = rnd;
            end
            LOAD: begin
                bus.read_enable = 1'b1;
                busy            = 1'b1;
            end
            ARK0: begin
                bus.around_enable = 1'b1;
                bus.round_key_idx = ROUND_W'(NUM_ROUNDS);
                busy              = 1'b1;
            end
            ISROWS: begin
                bus.isrows_enable = 1'b1;
                busy              = 1'b1;
            end
            ISBYTES: begin
                bus.isbytes_enable = 1'b1;
                busy               = 1'b1;
            end
            ARK: begin
                bus.around_enable = 1'b1;
                bus.round_key_idx = rnd;
                busy              = 1'b1;
            end
            IMCOL: begin
                bus.imcol_enable = 1'b1;
                busy             = 1'b1;
            end
            DONE:    bus.HREADYOUT    = 1'b1;
            SEND:    bus.write_enable = 1'b1;
            default: ;
        endcase
    end

endmodule
